ex_div_unit: RTL



---
 rtl/ex_div_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ex_div_unit.sv
// Iterative 32-bit RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the EX stage.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow right after acceptance.
module ex_div_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic        FLUSH,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [32:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] res_q, res_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        valid_op, in_signed, sign1, sign2, in_dz, in_ovf;
    logic [32:0] ext1, ext2, abs1, abs2;
    logic [33:0] shifted, diff;
    logic [31:0] quo_fix, rem_fix;

    // Magnitudes are formed at 33 bits so that 0x80000000 keeps its true value.
    assign valid_op  = (SELECT[4:2] == 3'b011);
    assign in_signed = ~SELECT[0];
    assign sign1     = in_signed & DATA1[31];
    assign sign2     = in_signed & DATA2[31];
    assign ext1      = {sign1, DATA1};
    assign ext2      = {sign2, DATA2};
    assign abs1      = sign1 ? (33'd0 - ext1) : ext1;
    assign abs2      = sign2 ? (33'd0 - ext2) : ext2;
    assign in_dz     = (DATA2 == 32'd0);
    assign in_ovf    = in_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);

    // One restoring step: {rem,quo} shifts left and the divisor is trial-subtracted.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, divisor_q};
    assign quo_fix = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    assign rem_fix = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (START && valid_op) begin
                    op_d      = SELECT[1:0];
                    quo_d     = abs1[31:0];
                    rem_d     = {32'd0, abs1[32]};
                    divisor_d = abs2;
                    neg_quo_d = (sign1 ^ sign2) & ~in_dz;
                    neg_rem_d = sign1;
                    dz_d      = in_dz;
                    ovf_d     = in_ovf;
                    cnt_d     = 5'd31;
                    state_d   = S_CALC;
`ifdef DIV_FAST_SPECIAL_EN
                    if (in_dz || in_ovf) begin
                        state_d = S_DONE;
                        if (SELECT[1])
                            res_d = in_dz ? DATA1 : 32'd0;
                        else
                            res_d = in_dz ? 32'hFFFF_FFFF : 32'h8000_0000;
                    end
`endif
                end
            end
            S_CALC: begin
                quo_d = {quo_q[30:0], ~diff[33]};
                rem_d = diff[33] ? shifted[32:0] : diff[32:0];
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0)
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1])
                    res_d = ovf_q ? 32'd0 : rem_fix;
                else if (dz_q)
                    res_d = 32'hFFFF_FFFF;
                else if (ovf_q)
                    res_d = 32'h8000_0000;
                else
                    res_d = quo_fix;
                state_d = S_DONE;
            end
            default: begin
                done_d   = 1'b1;
                result_d = res_q;
                state_d  = S_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight, including a result about to be published.
        if (FLUSH) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            quo_q     <= 32'd0;
            rem_q     <= 33'd0;
            divisor_q <= 33'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            res_q     <= 32'd0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule
